// File: rtl/alu_sequencer.sv
// Multi-cycle issue controller: accepts one instruction, steps it through READ/EXEC/WB, traps illegal encodings.
// Optional retire counter output enabled by defining ALU_SEQ_RETIRE_CNT_EN.
module alu_sequencer #(
    parameter int REG_ADDR_W = 3,
    parameter int DATA_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [1:0]            instr_opcode,
    input  logic [3:0]            instr_func,
    input  logic [REG_ADDR_W-1:0] instr_rd,
    input  logic [REG_ADDR_W-1:0] instr_rs,
    input  logic [REG_ADDR_W-1:0] instr_rt,
    input  logic [DATA_W-1:0]     instr_imm,
    input  logic                  ex_stall,
    output logic                  rf_rd_en,
    output logic [REG_ADDR_W-1:0] rf_rd_addr_a,
    output logic [REG_ADDR_W-1:0] rf_rd_addr_b,
    output logic [3:0]            alu_code,
    output logic                  alu_src_imm,
    output logic [DATA_W-1:0]     imm_out,
    output logic                  rf_wr_en,
    output logic [REG_ADDR_W-1:0] rf_wr_addr,
    output logic                  rf_wr_sel,
    output logic                  illegal,
`ifdef ALU_SEQ_RETIRE_CNT_EN
    output logic [15:0]           retire_cnt,
`endif
    output logic                  busy
);

    // state | meaning
    // IDLE  | waiting for an instruction (ready after one settling cycle)
    // READ  | register-file read strobe
    // EXEC  | ALU code valid, held while ex_stall
    // WB    | register-file write strobe
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    logic [1:0] state;

    logic [3:0] d_alu;
    logic       d_imm, d_li, d_read, d_write, d_ill;

    logic [3:0] q_alu;
    logic       q_imm, q_li, q_write, q_ill;

    always_comb begin
        d_alu   = 4'b0000;
        d_imm   = 1'b0;
        d_li    = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
        d_ill   = 1'b0;
        case (instr_opcode)
            2'b01: begin d_alu = 4'b0001; d_read = 1'b1; d_write = 1'b1; end
            2'b10: begin d_alu = 4'b0010; d_read = 1'b1; d_write = 1'b1; end
            2'b11: d_ill = 1'b1;
            default: begin
                case (instr_func)
                    4'b0000: ;
                    4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101: begin
                        d_alu = instr_func; d_read = 1'b1; d_write = 1'b1;
                    end
                    4'b0110: begin d_alu = 4'b0001; d_imm = 1'b1; d_read = 1'b1; d_write = 1'b1; end
                    4'b0111: begin d_alu = 4'b0010; d_imm = 1'b1; d_read = 1'b1; d_write = 1'b1; end
                    4'b1000: begin d_li = 1'b1; d_write = 1'b1; end
                    default: d_ill = 1'b1;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            instr_ready  <= 1'b0;
            rf_rd_en     <= 1'b0;
            rf_rd_addr_a <= '0;
            rf_rd_addr_b <= '0;
            alu_code     <= 4'b0000;
            alu_src_imm  <= 1'b0;
            imm_out      <= '0;
            rf_wr_en     <= 1'b0;
            rf_wr_addr   <= '0;
            rf_wr_sel    <= 1'b0;
            illegal      <= 1'b0;
            busy         <= 1'b0;
            q_alu        <= 4'b0000;
            q_imm        <= 1'b0;
            q_li         <= 1'b0;
            q_write      <= 1'b0;
            q_ill        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (instr_ready && instr_valid) begin
                        q_alu        <= d_alu;
                        q_imm        <= d_imm;
                        q_li         <= d_li;
                        q_write      <= d_write;
                        q_ill        <= d_ill;
                        imm_out      <= instr_imm;
                        rf_rd_addr_a <= instr_rs;
                        rf_rd_addr_b <= instr_rt;
                        rf_wr_addr   <= instr_rd;
                        rf_rd_en     <= d_read;
                        instr_ready  <= 1'b0;
                        busy         <= 1'b1;
                        state        <= S_READ;
                    end else begin
                        instr_ready  <= 1'b1;
                    end
                end
                S_READ: begin
                    rf_rd_en    <= 1'b0;
                    alu_code    <= q_alu;
                    alu_src_imm <= q_imm;
                    rf_wr_sel   <= q_li;
                    illegal     <= q_ill;
                    state       <= S_EXEC;
                end
                S_EXEC: begin
                    // trap pulse covers only the first EXEC cycle, even under stall
                    illegal <= 1'b0;
                    if (!ex_stall) begin
                        rf_wr_en <= q_write;
                        state    <= S_WB;
                    end
                end
                default: begin
                    rf_wr_en    <= 1'b0;
                    alu_code    <= 4'b0000;
                    alu_src_imm <= 1'b0;
                    rf_wr_sel   <= 1'b0;
                    busy        <= 1'b0;
                    instr_ready <= 1'b1;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_RETIRE_CNT_EN
    logic [15:0] retire_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_q <= 16'h0000;
        end else if (state == S_WB && rf_wr_en) begin
            retire_q <= retire_q + 16'h0001;
        end
    end

    assign retire_cnt = retire_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: steps instructions cycle by cycle against hand-computed strobes.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [1:0]  instr_opcode = 2'b00;
    logic [3:0]  instr_func = 4'b0000;
    logic [2:0]  instr_rd = 3'd0;
    logic [2:0]  instr_rs = 3'd0;
    logic [2:0]  instr_rt = 3'd0;
    logic [15:0] instr_imm = 16'h0000;
    logic        ex_stall = 1'b0;
    logic        rf_rd_en;
    logic [2:0]  rf_rd_addr_a;
    logic [2:0]  rf_rd_addr_b;
    logic [3:0]  alu_code;
    logic        alu_src_imm;
    logic [15:0] imm_out;
    logic        rf_wr_en;
    logic [2:0]  rf_wr_addr;
    logic        rf_wr_sel;
    logic        illegal;
    logic        busy;
`ifdef ALU_SEQ_RETIRE_CNT_EN
    logic [15:0] retire_cnt;
`endif

    int ntests = 0;
    int nfail  = 0;

    alu_sequencer #(.REG_ADDR_W(3), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_opcode(instr_opcode), .instr_func(instr_func),
        .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_rt(instr_rt),
        .instr_imm(instr_imm), .ex_stall(ex_stall),
        .rf_rd_en(rf_rd_en), .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
        .alu_code(alu_code), .alu_src_imm(alu_src_imm), .imm_out(imm_out),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_sel(rf_wr_sel),
        .illegal(illegal),
`ifdef ALU_SEQ_RETIRE_CNT_EN
        .retire_cnt(retire_cnt),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // presents one instruction for exactly the accept edge; returns sampled in READ
    task automatic issue(input logic [1:0] op, input logic [3:0] fn, input logic [2:0] rd,
                         input logic [2:0] rs, input logic [2:0] rt, input logic [15:0] imm);
        instr_opcode = op;
        instr_func   = fn;
        instr_rd     = rd;
        instr_rs     = rs;
        instr_rt     = rt;
        instr_imm    = imm;
        instr_valid  = 1'b1;
        step();
        instr_valid  = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, {31'd0, instr_ready}, 32'd0);
        chk({tag, "_rden"},  {31'd0, rf_rd_en},    32'd0);
        chk({tag, "_wren"},  {31'd0, rf_wr_en},    32'd0);
        chk({tag, "_alu"},   {28'd0, alu_code},    32'd0);
        chk({tag, "_ill"},   {31'd0, illegal},     32'd0);
        chk({tag, "_busy"},  {31'd0, busy},        32'd0);
        chk({tag, "_imm"},   {16'd0, imm_out},     32'd0);
    endtask

    initial begin
        // reset held across clock edges
        step();
        step();
        chk_all_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rst_rel_ready", {31'd0, instr_ready}, 32'd1);

        // add via func 0001; garbage on the bus mid-instruction must be ignored
        issue(2'b00, 4'b0001, 3'd3, 3'd1, 3'd2, 16'h1234);
        chk("add_rd_en", {31'd0, rf_rd_en}, 32'd1);
        chk("add_addr_a", {29'd0, rf_rd_addr_a}, 32'd1);
        chk("add_addr_b", {29'd0, rf_rd_addr_b}, 32'd2);
        chk("add_ready_lo", {31'd0, instr_ready}, 32'd0);
        chk("add_busy", {31'd0, busy}, 32'd1);
        instr_valid = 1'b1; instr_rd = 3'd7; instr_rs = 3'd6; instr_imm = 16'hFFFF;
        step();
        chk("add_alu", {28'd0, alu_code}, 32'd1);
        chk("add_rd_en_off", {31'd0, rf_rd_en}, 32'd0);
        chk("add_hold_a", {29'd0, rf_rd_addr_a}, 32'd1);
        step();
        instr_valid = 1'b0;
        chk("add_wr_en", {31'd0, rf_wr_en}, 32'd1);
        chk("add_wr_addr", {29'd0, rf_wr_addr}, 32'd3);
        chk("add_wr_sel", {31'd0, rf_wr_sel}, 32'd0);
        chk("add_hold_imm", {16'd0, imm_out}, 32'h1234);
        step();
        chk("add_ready_back", {31'd0, instr_ready}, 32'd1);
        chk("add_wr_en_off", {31'd0, rf_wr_en}, 32'd0);
        chk("add_alu_clr", {28'd0, alu_code}, 32'd0);
        chk("add_busy_off", {31'd0, busy}, 32'd0);

        // addi with two stall cycles in EXEC
        issue(2'b00, 4'b0110, 3'd5, 3'd6, 3'd0, 16'h0005);
        chk("addi_rd_en", {31'd0, rf_rd_en}, 32'd1);
        ex_stall = 1'b1;
        step();
        chk("addi_alu", {28'd0, alu_code}, 32'd1);
        chk("addi_src", {31'd0, alu_src_imm}, 32'd1);
        chk("addi_imm", {16'd0, imm_out}, 32'h0005);
        step();
        chk("addi_stall1_wr", {31'd0, rf_wr_en}, 32'd0);
        step();
        chk("addi_stall2_alu", {28'd0, alu_code}, 32'd1);
        chk("addi_stall2_wr", {31'd0, rf_wr_en}, 32'd0);
        ex_stall = 1'b0;
        step();
        chk("addi_wr_en", {31'd0, rf_wr_en}, 32'd1);
        chk("addi_wr_addr", {29'd0, rf_wr_addr}, 32'd5);
        chk("addi_src_wb", {31'd0, alu_src_imm}, 32'd1);
        step();
        chk("addi_ready", {31'd0, instr_ready}, 32'd1);
        chk("addi_src_clr", {31'd0, alu_src_imm}, 32'd0);

        // li
        issue(2'b00, 4'b1000, 3'd4, 3'd2, 3'd3, 16'h00AA);
        chk("li_rd_en", {31'd0, rf_rd_en}, 32'd0);
        step();
        chk("li_alu", {28'd0, alu_code}, 32'd0);
        chk("li_imm", {16'd0, imm_out}, 32'h00AA);
        step();
        chk("li_wr_en", {31'd0, rf_wr_en}, 32'd1);
        chk("li_wr_addr", {29'd0, rf_wr_addr}, 32'd4);
        chk("li_wr_sel", {31'd0, rf_wr_sel}, 32'd1);
        step();
        chk("li_wr_sel_clr", {31'd0, rf_wr_sel}, 32'd0);

        // illegal opcode 11
        issue(2'b11, 4'b0001, 3'd1, 3'd1, 3'd1, 16'h0000);
        chk("ill11_rd_en", {31'd0, rf_rd_en}, 32'd0);
        chk("ill11_pre", {31'd0, illegal}, 32'd0);
        step();
        chk("ill11_pulse", {31'd0, illegal}, 32'd1);
        chk("ill11_alu", {28'd0, alu_code}, 32'd0);
        step();
        chk("ill11_pulse_end", {31'd0, illegal}, 32'd0);
        chk("ill11_wr_en", {31'd0, rf_wr_en}, 32'd0);
        step();
        chk("ill11_ready", {31'd0, instr_ready}, 32'd1);

        // illegal func 1111
        issue(2'b00, 4'b1111, 3'd2, 3'd1, 3'd1, 16'h0000);
        step();
        chk("ill_f_pulse", {31'd0, illegal}, 32'd1);
        chk("ill_f_alu", {28'd0, alu_code}, 32'd0);
        step();
        chk("ill_f_wr_en", {31'd0, rf_wr_en}, 32'd0);
        step();
        chk("ill_f_ready", {31'd0, instr_ready}, 32'd1);

        // nop: no read, no write
        issue(2'b00, 4'b0000, 3'd6, 3'd1, 3'd2, 16'h0000);
        chk("nop_rd_en", {31'd0, rf_rd_en}, 32'd0);
        step();
        step();
        chk("nop_wr_en", {31'd0, rf_wr_en}, 32'd0);
        chk("nop_busy", {31'd0, busy}, 32'd1);
        step();

        // sub aborted by reset in EXEC
        issue(2'b10, 4'b0000, 3'd2, 3'd3, 3'd4, 16'h0077);
        step();
        chk("sub_alu", {28'd0, alu_code}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        step();
        chk("abort_no_wr", {31'd0, rf_wr_en}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("abort_ready", {31'd0, instr_ready}, 32'd1);

`ifdef ALU_SEQ_RETIRE_CNT_EN
        dut.retire_q = 16'hFFFE;
`endif
        // add via opcode 01 after the abort
        issue(2'b01, 4'b1111, 3'd0, 3'd5, 3'd6, 16'h0000);
        chk("op01_rd_en", {31'd0, rf_rd_en}, 32'd1);
        chk("op01_addr_a", {29'd0, rf_rd_addr_a}, 32'd5);
        step();
        chk("op01_alu", {28'd0, alu_code}, 32'd1);
        step();
        chk("op01_wr_en", {31'd0, rf_wr_en}, 32'd1);
        chk("op01_wr_addr", {29'd0, rf_wr_addr}, 32'd0);
        step();
`ifdef ALU_SEQ_RETIRE_CNT_EN
        chk("retire_ffff", {16'd0, retire_cnt}, 32'h0000FFFF);
        issue(2'b00, 4'b1000, 3'd1, 3'd0, 3'd0, 16'h0001);
        step();
        step();
        step();
        chk("retire_wrap", {16'd0, retire_cnt}, 32'h00000000);
`endif

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
